// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word deframer.
package uart_pkg;

    typedef enum logic [1:0] {
        HUNT        = 2'd0,
        PAYLOAD     = 2'd1,
        EXPECT_SYNC = 2'd2
    } deframer_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h0F;

    // Ceiling log2, never below 1 so that derived vectors always have at least one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/link_timeout_cnt.sv
// Counts baud ticks since the last received byte and flags the tick that breaks the link.
module link_timeout_cnt
    import uart_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_tick,
    input  logic data_tick,
    output logic expired
);

    localparam int CNT_W = clog2(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_TICKS - 1);

    logic [CNT_W-1:0] count;

    // A received byte always wins over a simultaneous baud tick, so it blocks expiry.
    assign expired = (count == CNT_MAX) && clk_tick && !data_tick;

    // Idle counter: cleared by traffic, restarted after expiry, otherwise advanced by baud ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (data_tick) begin
            count <= '0;
        end else if (expired) begin
            count <= '0;
        end else if (clk_tick) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_word_deframer.sv
// Reassembles sync-prefixed UART byte frames into multi-byte words, MSB first.
module uart_word_deframer
    import uart_pkg::*;
#(
    parameter int         WORD_BYTES         = 2,
    parameter logic [7:0] SYNC_BYTE          = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_TICKS      = 64,
    parameter int         RESYNC_EVERY_FRAME = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_tick,
    input  logic                    data_tick,
    input  logic [7:0]              din,
    output logic [8*WORD_BYTES-1:0] dout,
    output logic                    dout_valid,
    output logic                    con_broken,
    output logic                    frame_err
);

    localparam int IDX_W = clog2(WORD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    deframer_state_t         state, state_next;
    logic [IDX_W-1:0]        index, index_next;
    logic [8*WORD_BYTES-1:0] assembly, assembly_next;
    logic [8*WORD_BYTES-1:0] dout_next;
    logic                    dout_valid_next;
    logic                    con_broken_next;
    logic                    frame_err_next;
    logic                    expired;

    link_timeout_cnt #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clk_tick (clk_tick),
        .data_tick(data_tick),
        .expired  (expired)
    );

    // State, assembly and all outputs are registered together so outputs change on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            index      <= '0;
            assembly   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            con_broken <= 1'b1;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            index      <= index_next;
            assembly   <= assembly_next;
            dout       <= dout_next;
            dout_valid <= dout_valid_next;
            con_broken <= con_broken_next;
            frame_err  <= frame_err_next;
        end
    end

    // Frame tracking: hunt for sync, collect payload bytes, then demand sync again or stream on.
    always_comb begin
        state_next      = state;
        index_next      = index;
        assembly_next   = assembly;
        dout_next       = dout;
        dout_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        case (state)
            HUNT: begin
                if (data_tick && (din == SYNC_BYTE)) begin
                    state_next    = PAYLOAD;
                    index_next    = '0;
                    assembly_next = '0;
                end
            end

            PAYLOAD: begin
                if (data_tick) begin
                    assembly_next[8*(WORD_BYTES-1-int'(index)) +: 8] = din;
                    if (index == LAST_IDX) begin
                        dout_next       = assembly_next;
                        dout_valid_next = 1'b1;
                        index_next      = '0;
                        assembly_next   = '0;
                        state_next      = (RESYNC_EVERY_FRAME != 0) ? EXPECT_SYNC : PAYLOAD;
                    end else begin
                        index_next = index + IDX_W'(1);
                    end
                end else if (expired) begin
                    state_next    = HUNT;
                    index_next    = '0;
                    assembly_next = '0;
                end
            end

            EXPECT_SYNC: begin
                if (data_tick) begin
                    if (din == SYNC_BYTE) begin
                        state_next    = PAYLOAD;
                        index_next    = '0;
                        assembly_next = '0;
                    end else begin
                        state_next     = HUNT;
                        frame_err_next = 1'b1;
                        index_next     = '0;
                        assembly_next  = '0;
                    end
                end else if (expired) begin
                    state_next    = HUNT;
                    index_next    = '0;
                    assembly_next = '0;
                end
            end

            default: begin
                state_next    = HUNT;
                index_next    = '0;
                assembly_next = '0;
            end
        endcase

        con_broken_next = (state_next == HUNT);
    end

endmodule

// File: doc/uart_word_deframer.md
Name: uart_word_deframer

Overview:
- Reassembles a stream of UART bytes into WORD_BYTES-wide words.
- Each frame is one SYNC_BYTE followed by WORD_BYTES payload bytes, sent MSB first.
- Tracks link health with a tick-based timeout and flags framing errors.
- Sits between the UART receiver (din/data_tick) and game-state logic, as the generalised successor of the fixed 2-byte converter.

Parameters:
- WORD_BYTES, 2, payload bytes per frame (1..8); dout width is 8*WORD_BYTES.
- SYNC_BYTE, 8'h0F, frame-start keyword.
- TIMEOUT_TICKS, 64, number of clk_tick periods without a data_tick that breaks the link (2..65535).
- RESYNC_EVERY_FRAME, 1. 1: every frame needs SYNC_BYTE. 0: SYNC_BYTE only after link loss, then payload bytes run back-to-back.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- clk_tick  in  1  baud-rate sample-tick strobe (timeout time base)
- data_tick  in  1  one-cycle strobe: din holds a new received byte
- din  in  8  received byte, valid when data_tick=1
- dout  out  8*WORD_BYTES  last complete word; byte 0 received lands in the MSB
- dout_valid  out  1  one-cycle pulse when dout updates
- con_broken  out  1  1 = link not synchronised
- frame_err  out  1  one-cycle pulse: non-sync byte arrived where sync was expected while locked

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Reset values: dout=0, dout_valid=0, con_broken=1, frame_err=0, state=HUNT, byte index=0, timeout counter=0, assembly register=0.
- All outputs are registered. Reset mid-frame discards the partial word.
- State HUNT (con_broken=1):
  - data_tick with din==SYNC_BYTE -> PAYLOAD, index=0.
  - Any other byte is ignored, with no error pulse.
  - con_broken goes to 0 on the cycle after the accepted sync byte.
- State PAYLOAD (con_broken=0):
  - Each data_tick stores din into byte slot index of the assembly register; index increments.
  - When index==WORD_BYTES-1 on data_tick:
    - dout is loaded with the full word, including the current din, on the next edge; dout_valid=1 for exactly that one cycle.
    - index returns to 0.
    - Next state is EXPECT_SYNC if RESYNC_EVERY_FRAME=1, otherwise PAYLOAD.
  - Latency: dout/dout_valid are visible 1 clk after the last payload data_tick.
  - A payload byte equal to SYNC_BYTE is treated as data, never as a resync.
- State EXPECT_SYNC (con_broken=0):
  - data_tick with din==SYNC_BYTE -> PAYLOAD, index=0.
  - Otherwise: frame_err pulses 1 cycle, con_broken=1, state -> HUNT.
- dout holds its value between updates and through link loss. It is never cleared except by rst.
- Timeout counter (width clog2(TIMEOUT_TICKS)):
  - data_tick clears it. If data_tick and clk_tick arrive in the same cycle, data_tick wins.
  - Otherwise clk_tick increments it; it saturates at TIMEOUT_TICKS-1.
  - Counter at TIMEOUT_TICKS-1, clk_tick=1 and data_tick=0, in PAYLOAD or EXPECT_SYNC: state -> HUNT, con_broken=1, partial word dropped, counter -> 0, no dout_valid, no frame_err.
  - The timeout has no effect in HUNT.
- Simultaneous cases:
  - Timeout condition and data_tick in the same cycle: the byte is processed and no timeout occurs.
  - A data_tick whose byte completes a word never coincides with a timeout, by the rule above.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {HUNT, PAYLOAD, EXPECT_SYNC};
  - default SYNC_BYTE constant 8'h0F;
  - a clog2 helper function.
- Sub-module link_timeout_cnt (params TIMEOUT_TICKS; ports clk, rst, clk_tick, data_tick, expired) implements the saturating counter. expired is combinational: counter at max && clk_tick && !data_tick.
- FSM and assembly register stay in the top module.

Test Plan:
- WORD_BYTES=2, RESYNC=1: bytes 0x0F,0xAB,0xCD -> con_broken falls after 0x0F; dout=16'hABCD with a single dout_valid pulse 1 clk after the 0xCD tick.
- WORD_BYTES=4: 0x0F,0x11,0x22,0x33,0x44,0x0F,0x55,0x66,0x77,0x88 -> two dout_valid pulses, dout=32'h11223344 then 32'h55667788.
- RESYNC=1, locked, after one full frame send 0x99 instead of 0x0F -> frame_err pulse, con_broken=1, dout unchanged; a later 0x0F,0x01,0x02 relocks and gives 16'h0102.
- TIMEOUT_TICKS=64: after 0x0F,0xAB send 64 clk_ticks with no data -> con_broken=1 on tick 64, no dout_valid; next 0xCD is ignored (HUNT).
- Same as above but data_tick coincides with the 64th clk_tick -> no timeout, word completes normally.
- RESYNC=0: 0x0F,0x12,0x34,0x0F,0x56 -> words 16'h1234 then 16'h0F56 (sync value accepted as payload); rst asserted mid-word -> all outputs return to reset values.
